if_id_skid_reg: RTL and testbench
=================================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: instruction width in bits.
REQ-002 The block SHALL have parameter PC_W, default 32: PC width in bits.
REQ-003 The block SHALL have parameter BUBBLE, default 0 (DATA_W bits): instruction value driven whenever out_valid=0.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1: upstream IF offers an instruction.
REQ-008 The block SHALL have port in_ready, output, 1: block can accept an instruction this cycle.
REQ-009 The block SHALL have port in_instr, input, DATA_W: instruction from memory.
REQ-010 The block SHALL have port in_pc, input, PC_W: PC of in_instr.
REQ-011 The block SHALL have port out_valid, output, 1: an instruction is presented to ID.
REQ-012 The block SHALL have port out_ready, input, 1: ID consumes the presented instruction this cycle.
REQ-013 The block SHALL have port out_instr, output, DATA_W: instruction to ID.
REQ-014 The block SHALL have port out_pc, output, PC_W: PC of out_instr; 0 when out_valid=0.
REQ-015 The block SHALL have port occupancy, output, 2: entries held (0..2).

Function
REQ-016 Accept = in_valid & in_ready; consume = out_valid & out_ready; both SHALL be evaluated at the same edge.
REQ-017 Storage SHALL be two entries, main and skid; out_* SHALL be driven from main only.
REQ-018 in_ready SHALL be a registered output equal to 1 exactly when skid is empty; it SHALL not depend combinationally on out_ready.
REQ-019 States SHALL be EMPTY (occupancy 0), ONE (main full, occupancy 1), TWO (main and skid full, occupancy 2); out_valid=1 in ONE and TWO.
REQ-020 EMPTY + accept SHALL load main -> ONE; EMPTY without accept SHALL stay EMPTY.
REQ-021 ONE + accept + consume SHALL load main with the input -> ONE; ONE + accept only SHALL load skid -> TWO; ONE + consume only -> EMPTY; neither -> ONE, holding main.
REQ-022 TWO + consume SHALL move skid to main -> ONE; TWO without consume -> TWO, holding both; accept is impossible in TWO.
REQ-023 Latency from accept to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 instruction/cycle with out_ready held high.
REQ-024 Order SHALL be preserved: instructions leave in acceptance order, and no instruction is duplicated or lost except by flush.
REQ-025 The {instr, pc} pair SHALL stay associated through both entries.
REQ-026 Held out_instr/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 A flush at an edge SHALL make the next state EMPTY with in_ready=1, overriding any accept in that cycle; the offered input is dropped.
REQ-028 A consume in a flush cycle SHALL count as completed (ID already sampled it).
REQ-029 When out_valid=0, out_instr SHALL equal BUBBLE and out_pc SHALL equal 0.

Reset
REQ-030 With reset=1 at an edge, the block SHALL go to EMPTY: out_valid=0, out_instr=BUBBLE, out_pc=0, occupancy=0, in_ready=1.
REQ-031 Reset SHALL take priority over flush, accept, and consume, including mid-operation in state TWO.
REQ-032 Reset SHALL be ignored between edges (synchronous only).

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum {EMPTY, ONE, TWO} and the default BUBBLE constant, shared with the other pipeline registers.
REQ-034 One sub-module, pipe_entry (a DATA_W+PC_W register with load enable and synchronous clear), SHALL be instantiated twice, for main and skid.

Verification
REQ-035 Scenario: reset, then accept 0xE3A01005 with PC 0x100 while out_ready=1 -> next cycle out_valid=1, out_instr=0xE3A01005, out_pc=0x100, occupancy=1.
REQ-036 Scenario: stream instructions 1..8 with out_ready=1 every cycle -> out_instr shows 1..8 on consecutive cycles, with no gaps.
REQ-037 Scenario: out_ready=0, then offer A and B -> occupancy=2 and in_ready=0; C offered is not accepted; after out_ready=1, the output order is A, B, C.
REQ-038 Scenario: in TWO, assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_instr=BUBBLE, in_ready=1, and the offered instruction never appears.
REQ-039 Scenario: in TWO, assert reset together with flush, in_valid and out_ready -> next cycle all outputs equal their reset values.
REQ-040 Scenario: run 10k random in_valid/out_ready/flush cycles against a scoreboard model -> zero order or data mismatches, and occupancy always equals the model count.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register family: occupancy states and
// the default bubble instruction injected when a stage holds nothing.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam logic [31:0] BUBBLE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of a pipeline register: W-bit payload with a load enable
// and a synchronous clear that wins over load.
module pipe_entry #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-deep skid buffer: full throughput while
// in_ready stays a pure flop output, decoupled from out_ready.
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                PC_W   = 32,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    localparam int ENTRY_W = DATA_W + PC_W;

    occ_state_t         state_q, state_d;
    logic               in_ready_q;
    logic               accept, consume;
    logic               main_load, main_from_skid, skid_load, discard;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;

    assign accept   = in_valid & in_ready_q;
    assign consume  = (state_q != EMPTY) & out_ready;
    assign discard  = reset | flush;
    assign in_entry = {in_instr, in_pc};
    assign main_d   = main_from_skid ? skid_q : in_entry;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Reset and flush override everything; a consume this cycle has
        // already been sampled by ID and needs no extra handling.
        if (discard) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // NOTE: payload slots are cleared on reset/flush only for determinism;
    // outputs are already masked by out_valid, so correctness never depends on it.
    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk   (clk),
        .clear (discard),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .clear (discard),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_instr = out_valid ? main_q[ENTRY_W-1:PC_W] : BUBBLE;
    assign out_pc    = out_valid ? main_q[PC_W-1:0] : '0;
    assign occupancy = 2'(state_q);

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench: FIFO-of-two scoreboard compared every cycle, plus
// directed scenarios with literal expectations.
module tb_if_id_skid_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    item_t model_q[$];
    bit    model_live = 1'b0;

    if_id_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a bounded queue of at most two {instr, pc} items.
    always @(posedge clk) begin
        if (reset) begin
            model_q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            bit acc, con;
            con = (model_q.size() > 0) && out_ready;
            acc = in_valid && (model_q.size() < 2);
            if (con) void'(model_q.pop_front());
            if (flush) model_q.delete();
            else if (acc) model_q.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            int n;
            n = model_q.size();
            check("occupancy", 64'(occupancy), 64'(n));
            check("in_ready", 64'(in_ready), 64'(n < 2));
            check("out_valid", 64'(out_valid), 64'(n > 0));
            check("out_instr", 64'(out_instr), (n > 0) ? 64'(model_q[0].instr) : 64'h0);
            check("out_pc", 64'(out_pc), (n > 0) ? 64'(model_q[0].pc) : 64'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_out_instr"}, 64'(out_instr), 64'h0);
        check({tag, "_out_pc"}, 64'(out_pc), 64'h0);
        check({tag, "_occupancy"}, 64'(occupancy), 64'h0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    endtask

    task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        offer(1'b1, a, 32'h200);
        step();
        offer(1'b1, b, 32'h204);
        step();
        check("fill_occupancy", 64'(occupancy), 64'h2);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        check_reset_values("rst");

        // Single accept, one-cycle latency.
        out_ready = 1'b1;
        offer(1'b1, 32'hE3A0_1005, 32'h100);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("lat_valid", 64'(out_valid), 64'h1);
        check("lat_instr", 64'(out_instr), 64'hE3A0_1005);
        check("lat_pc", 64'(out_pc), 64'h100);
        check("lat_occ", 64'(occupancy), 64'h1);
        step();

        // Back-to-back stream with no gaps.
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, 32'(i), 32'(i * 4));
            step();
            check("stream_instr", 64'(out_instr), 64'(i));
            check("stream_valid", 64'(out_valid), 64'h1);
        end
        offer(1'b0, 32'h0, 32'h0);
        step();
        check("stream_drain", 64'(out_valid), 64'h0);

        // Backpressure: A, B fill both slots, C must wait.
        fill_two(32'hAAAA_0001, 32'hBBBB_0002);
        check("bp_in_ready", 64'(in_ready), 64'h0);
        offer(1'b1, 32'hCCCC_0003, 32'h208);
        step();
        check("bp_hold_instr", 64'(out_instr), 64'hAAAA_0001);
        check("bp_hold_occ", 64'(occupancy), 64'h2);
        out_ready = 1'b1;
        step();
        check("bp_second", 64'(out_instr), 64'hBBBB_0002);
        check("bp_second_occ", 64'(occupancy), 64'h1);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("bp_third", 64'(out_instr), 64'hCCCC_0003);
        check("bp_third_pc", 64'(out_pc), 64'h208);
        step();
        check("bp_empty", 64'(occupancy), 64'h0);

        // Flush in TWO drops both entries and the offered instruction.
        fill_two(32'h1111_0001, 32'h2222_0002);
        offer(1'b1, 32'hDEAD_BEEF, 32'h300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check_reset_values("flush");
        out_ready = 1'b1;
        step();
        check("flush_gone", 64'(out_valid), 64'h0);

        // Reset beats flush/accept/consume while in TWO.
        fill_two(32'h3333_0003, 32'h4444_0004);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        offer(1'b1, 32'h5555_0005, 32'h400);
        step();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check_reset_values("rst_two");

        // Randomised traffic checked by the scoreboard at every negedge.
        for (int c = 0; c < 10000; c++) begin
            reset     = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            offer($urandom_range(0, 3) != 0, $urandom, $urandom);
            step();
        end
        reset = 1'b0; flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
